// File: rtl/shift_arbiter.sv
// Round-robin arbiter in front of a single shared barrel shifter.
// One transaction is in flight at a time: IDLE grants a requester, EXEC registers the result, RESP holds it.
`timescale 1ns/1ps

module shifter (
  input  logic [31:0] in,
  input  logic [1:0]  op,
  input  logic [31:0] shAmt,
  output logic [31:0] out
);
  logic       big;
  logic [4:0] amt;

  assign big = |shAmt[31:5];
  assign amt = shAmt[4:0];

  always_comb begin
    out = in;
    case (op)
      2'b00: out = big ? 32'd0 : (in << amt);
      2'b01: out = big ? 32'd0 : (in >> amt);
      2'b10: out = big ? {32{in[31]}} : 32'($signed(in) >>> amt);
      2'b11: out = (in >> amt) | (in << (6'd32 - {1'b0, amt}));
      default: out = in;
    endcase
  end
endmodule

module shift_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_in,
  input  logic [NREQ*32-1:0] req_shAmt,
  input  logic [NREQ*2-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_reg;
  logic [1:0]  ptr_reg;
  logic [31:0] opnd_reg;
  logic [31:0] amt_reg;
  logic [1:0]  op_reg;
  logic [1:0]  id_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_data_reg;
  logic [1:0]  rsp_id_reg;

  // Requester slices padded to four entries so a 2-bit id can always index them.
  logic [31:0] in_arr  [4];
  logic [31:0] amt_arr [4];
  logic [1:0]  op_arr  [4];
  logic [3:0]  valid_pad;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      if (gi < NREQ) begin : g_live
        assign in_arr[gi]    = req_in[32*gi +: 32];
        assign amt_arr[gi]   = req_shAmt[32*gi +: 32];
        assign op_arr[gi]    = req_op[2*gi +: 2];
        assign valid_pad[gi] = req_valid[gi];
      end else begin : g_pad
        assign in_arr[gi]    = 32'd0;
        assign amt_arr[gi]   = 32'd0;
        assign op_arr[gi]    = 2'd0;
        assign valid_pad[gi] = 1'b0;
      end
    end
  endgenerate

  logic       grant_valid;
  logic [1:0] grant_id;
  logic       found;
  logic [2:0] cand3;
  logic [2:0] next_ptr3;

  // Search from the pointer upward, wrapping at NREQ; first valid requester wins.
  always_comb begin
    found    = 1'b0;
    grant_id = 2'd0;
    cand3    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      cand3 = {1'b0, ptr_reg} + 3'(k);
      if (cand3 >= 3'(NREQ))
        cand3 = cand3 - 3'(NREQ);
      if (!found && valid_pad[cand3[1:0]]) begin
        found    = 1'b1;
        grant_id = cand3[1:0];
      end
    end
  end

  assign grant_valid = (state_reg == IDLE) && !reset && found;
  assign next_ptr3   = {1'b0, grant_id} + 3'd1;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_valid && (grant_id == 2'(gi));
    end
  endgenerate

  logic [31:0] shift_out;

  shifter u_shifter (
    .in    (opnd_reg),
    .op    (op_reg),
    .shAmt (amt_reg),
    .out   (shift_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd0;
      opnd_reg      <= 32'd0;
      amt_reg       <= 32'd0;
      op_reg        <= 2'd0;
      id_reg        <= 2'd0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 32'd0;
      rsp_id_reg    <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            opnd_reg <= in_arr[grant_id];
            op_reg   <= op_arr[grant_id];
            // Rotates only need the low five bits; other ops see the full amount.
            amt_reg  <= (op_arr[grant_id] == 2'b11) ? {27'd0, amt_arr[grant_id][4:0]}
                                                    : amt_arr[grant_id];
            id_reg   <= grant_id;
            ptr_reg  <= (next_ptr3 == 3'(NREQ)) ? 2'd0 : next_ptr3[1:0];
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_reg  <= shift_out;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for shift_arbiter (NREQ=2).
`timescale 1ns/1ps

module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_in;
  logic [63:0] req_shAmt;
  logic [3:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  shift_arbiter #(.NREQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .req_shAmt (req_shAmt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [1:0]  op;
    logic [31:0] amt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bit-serial reference: one single-bit step per iteration.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] op,
                                        input logic [31:0] amt);
    logic [31:0] r;
    int n;
    r = a;
    if (op == 2'b11) n = int'(amt[4:0]);
    else if (amt >= 32'd32) n = 32;
    else n = int'(amt[4:0]);
    for (int i = 0; i < n; i++) begin
      case (op)
        2'b00: r = {r[30:0], 1'b0};
        2'b01: r = {1'b0, r[31:1]};
        2'b10: r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  task automatic set_req(input int id, input logic [31:0] a, input logic [1:0] op,
                         input logic [31:0] amt);
    req_in[32*id +: 32]    = a;
    req_shAmt[32*id +: 32] = amt;
    req_op[2*id +: 2]      = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int id, output bit ok);
    int n;
    n = 0;
    #1;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = req_ready[id];
    if (!ok) begin
      bad++;
      total++;
      $display("FAIL grant_timeout: req_ready=%b want bit %0d", req_ready, id);
    end
  endtask

  task automatic wait_rsp(output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
    if (!ok) begin
      bad++;
      total++;
      $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid);
    end
  endtask

  // Full single transaction with latency checks at N+1 (EXEC) and N+2 (RESP).
  task automatic do_op(input int id, input logic [31:0] a, input logic [1:0] op,
                       input logic [31:0] amt, input logic [31:0] exp);
    bit ok;
    logic [1:0] onehot;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(id, a, op, amt);
    req_valid = 2'b00;
    req_valid[id] = 1'b1;
    wait_ready(id, ok);
    if (!ok) begin
      req_valid = 2'b00;
      return;
    end
    onehot = 2'b00;
    onehot[id] = 1'b1;
    check("grant_onehot", 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid = 2'b00;
    check("exec_no_valid", 32'(rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("rsp_valid_n2", 32'(rsp_valid), 32'd1);
    check("rsp_data", rsp_data, exp);
    check("rsp_id", 32'(rsp_id), 32'(id));
    $display("txn id=%0d op=%0d in=%h amt=%h data=%h exp=%h", id, op, a, amt, rsp_data, exp);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int k;
    vecs[0]  = '{0, 32'h80000001, 2'b11, 32'd1,          32'hC0000000};
    vecs[1]  = '{1, 32'h80000000, 2'b10, 32'd40,         32'hFFFFFFFF};
    vecs[2]  = '{0, 32'h80000000, 2'b01, 32'd40,         32'h00000000};
    vecs[3]  = '{1, 32'h00000001, 2'b11, 32'd33,         32'h80000000};
    vecs[4]  = '{0, 32'h0000000F, 2'b00, 32'd4,          32'h000000F0};
    vecs[5]  = '{1, 32'hF0000000, 2'b01, 32'd4,          32'h0F000000};
    vecs[6]  = '{0, 32'h80000000, 2'b10, 32'd4,          32'hF8000000};
    vecs[7]  = '{1, 32'h12345678, 2'b11, 32'd8,          32'h78123456};
    vecs[8]  = '{0, 32'h00000001, 2'b00, 32'd31,         32'h80000000};
    vecs[9]  = '{1, 32'hFFFFFFFF, 2'b00, 32'd32,         32'h00000000};
    vecs[10] = '{0, 32'h7FFFFFFF, 2'b10, 32'd40,         32'h00000000};
    vecs[11] = '{1, 32'h12345678, 2'b11, 32'd0,          32'h12345678};
    vecs[12] = '{0, 32'hABCD1234, 2'b01, 32'hFFFFFFFF,   32'h00000000};
    vecs[13] = '{1, 32'h12345678, 2'b11, 32'd36,         32'h81234567};

    reset = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    req_in = '0;
    req_shAmt = '0;
    req_op = '0;

    // Reset state, with requests pending to show reset wins.
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    req_valid = 2'b00;
    reset = 1'b0;

    // rsp_ready while idle is ignored.
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rsp_ready_valid", 32'(rsp_valid), 32'd0);
    check("idle_rsp_ready_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].id, vecs[i].a, vecs[i].op, vecs[i].amt, vecs[i].exp);

    // Fairness: both requesters always valid, consumer always ready.
    do_reset();
    set_req(0, 32'h00000001, 2'b00, 32'd0);
    set_req(1, 32'h00000002, 2'b00, 32'd0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00)
        check("fair_ready_onehot", 32'($countones(req_ready)), 32'd1);
      if (rsp_valid) begin
        check("fair_id", 32'(rsp_id), 32'(k % 2));
        check("fair_data", rsp_data, (k % 2) ? 32'd2 : 32'd1);
        $display("txn fair k=%0d id=%0d data=%h", k, rsp_id, rsp_data);
        k++;
      end
    end
    check("fair_count", 32'(k), 32'd4);
    req_valid = 2'b00;

    // Backpressure: hold RESP for five cycles with both requesters waiting.
    do_reset();
    @(negedge clk);
    set_req(0, 32'h0000FFFF, 2'b00, 32'd8);
    set_req(1, 32'h00000003, 2'b01, 32'd1);
    req_valid = 2'b01;
    wait_ready(0, ok);
    @(negedge clk);
    req_valid = 2'b11;
    wait_rsp(ok);
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, 32'h00FFFF00);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    $display("txn backpressure id=%0d data=%h", rsp_id, rsp_data);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_next_grant_req1", 32'(req_ready), 32'd2);

    // Reset while in RESP drops the result and rewinds the pointer.
    do_reset();
    @(negedge clk);
    set_req(0, 32'h00000011, 2'b00, 32'd1);
    req_valid = 2'b01;
    wait_ready(0, ok);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(ok);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rstmid_ready_during", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("rstmid_grant_req0", 32'(req_ready), 32'd1);
    $display("txn reset_mid_resp req_ready=%b", req_ready);
    do_reset();

    // Random operations against the bit-serial model.
    for (int t = 0; t < 200; t++) begin
      int id;
      logic [31:0] a;
      logic [31:0] amt;
      logic [1:0] op;
      id  = int'($urandom_range(0, 1));
      a   = $urandom;
      op  = 2'($urandom_range(0, 3));
      amt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      do_op(id, a, op, amt, model(a, op, amt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
